ddr_cmd_scheduler: RTL and testbench

// - Upstream of the DDR4 pin-level command driver. Accepts decoded controller requests
//   (ACT/PRE/CAS_R/CAS_W/REF/MRS/ZQCL), buffers them, and releases at most one per clock.
// - Issues a request only when the DDR4 timing rules for it are met; emits DES otherwise.
// - Launches read/write data-burst start strobes CL/CWL clocks after each CAS.

---
 rtl/ddr_cmd_scheduler_pkg.sv | 37 +++
 rtl/ddr_sched_fifo.sv | 42 ++++
 rtl/ddr_cmd_scheduler.sv | 176 +++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_scheduler_pkg.sv
// rtl/ddr_cmd_scheduler_pkg.sv - shared command encoding, request record and DDR4 timing defaults
package ddr_cmd_scheduler_pkg;

  localparam int DDR_BG_WIDTH  = 2;
  localparam int DDR_BA_WIDTH  = 2;
  localparam int DDR_ROW_WIDTH = 15;
  localparam int DDR_COL_WIDTH = 10;

  localparam int DDR_T_RCD = 11;
  localparam int DDR_T_RP  = 11;
  localparam int DDR_T_RAS = 28;
  localparam int DDR_T_CCD = 4;
  localparam int DDR_T_RFC = 208;
  localparam int DDR_T_MOD = 24;
  localparam int DDR_CL    = 11;
  localparam int DDR_CWL   = 9;

  typedef enum logic [2:0] {
    CMD_DES   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_PRE   = 3'd2,
    CMD_CAS_R = 3'd3,
    CMD_CAS_W = 3'd4,
    CMD_REF   = 3'd5,
    CMD_MRS   = 3'd6,
    CMD_ZQCL  = 3'd7
  } cmd_e;

  typedef struct packed {
    cmd_e                     cmd;
    logic [DDR_BG_WIDTH-1:0]  bg;
    logic [DDR_BA_WIDTH-1:0]  ba;
    logic [DDR_ROW_WIDTH-1:0] row;
    logic [DDR_COL_WIDTH-1:0] col;
  } sched_req_t;

endpackage

// File: rtl/ddr_sched_fifo.sv
// rtl/ddr_sched_fifo.sv - synchronous request FIFO; full/empty from wrap-bit pointer compare
module ddr_sched_fifo
  import ddr_cmd_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock_t,
  input  logic       reset,
  input  logic       push,
  input  sched_req_t push_data,
  input  logic       pop,
  output sched_req_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  sched_req_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock_t) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - in-order DDR4 command scheduler with timing checks and burst strobes
module ddr_cmd_scheduler
  import ddr_cmd_scheduler_pkg::*;
#(
  parameter int BG_WIDTH   = DDR_BG_WIDTH,
  parameter int BA_WIDTH   = DDR_BA_WIDTH,
  parameter int ROW_WIDTH  = DDR_ROW_WIDTH,
  parameter int COL_WIDTH  = DDR_COL_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int T_RCD      = DDR_T_RCD,
  parameter int T_RP       = DDR_T_RP,
  parameter int T_RAS      = DDR_T_RAS,
  parameter int T_CCD      = DDR_T_CCD,
  parameter int T_RFC      = DDR_T_RFC,
  parameter int T_MOD      = DDR_T_MOD,
  parameter int CL         = DDR_CL,
  parameter int CWL        = DDR_CWL
) (
  input  logic                                 clock_t,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  cmd_e                                 req_cmd,
  input  logic [BG_WIDTH-1:0]                  req_bg,
  input  logic [BA_WIDTH-1:0]                  req_ba,
  input  logic [ROW_WIDTH-1:0]                 req_row,
  input  logic [COL_WIDTH-1:0]                 req_col,
  output cmd_e                                 out_cmd,
  output logic [BG_WIDTH-1:0]                  out_bg,
  output logic [BA_WIDTH-1:0]                  out_ba,
  output logic [ROW_WIDTH-1:0]                 out_row,
  output logic [COL_WIDTH-1:0]                 out_col,
  output logic                                 rd_start,
  output logic                                 wr_start,
  output logic                                 err_illegal,
  output logic [(1<<(BG_WIDTH+BA_WIDTH))-1:0]  bank_open
);

  localparam int BW       = BG_WIDTH + BA_WIDTH;
  localparam int NBANK    = 1 << BW;
  localparam int GLOB_MAX = (T_RFC > T_MOD) ? T_RFC : T_MOD;
  localparam int RCD_W    = $clog2(T_RCD + 1);
  localparam int RAS_W    = $clog2(T_RAS + 1);
  localparam int RP_W     = $clog2(T_RP + 1);
  localparam int CCD_W    = $clog2(T_CCD + 1);
  localparam int GLOB_W   = $clog2(GLOB_MAX + 1);

  sched_req_t        push_req;
  sched_req_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic              illegal;
  logic              skip;
  logic [BW-1:0]     b;
  logic              all_closed;

  logic [RCD_W-1:0]  trcd_cnt [NBANK];
  logic [RAS_W-1:0]  tras_cnt [NBANK];
  logic [RP_W-1:0]   trp_cnt  [NBANK];
  logic [CCD_W-1:0]  tccd_cnt;
  logic [GLOB_W-1:0] glob_cnt;
  logic [CL-1:0]     rd_pipe;
  logic [CWL-1:0]    wr_pipe;

  always_comb begin
    push_req     = '0;
    push_req.cmd = req_cmd;
    push_req.bg  = req_bg;
    push_req.ba  = req_ba;
    push_req.row = req_row;
    push_req.col = req_col;
  end

  assign req_ready = !fifo_full;

  ddr_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock_t   (clock_t),
    .reset     (reset),
    .push      (req_valid && !fifo_full),
    .push_data (push_req),
    .pop       (issue || illegal || skip),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign b          = {head.bg, head.ba};
  assign all_closed = (bank_open == '0);

  // A head that is not yet timing-legal simply waits; only structural errors are dropped.
  always_comb begin
    issue   = 1'b0;
    illegal = 1'b0;
    skip    = 1'b0;
    if (!fifo_empty) begin
      case (head.cmd)
        CMD_ACT: begin
          if (bank_open[b])                              illegal = 1'b1;
          else if (trp_cnt[b] == '0 && glob_cnt == '0)   issue   = 1'b1;
        end
        CMD_CAS_R, CMD_CAS_W: begin
          if (!bank_open[b])                             illegal = 1'b1;
          else if (trcd_cnt[b] == '0 && tccd_cnt == '0)  issue   = 1'b1;
        end
        CMD_PRE:  issue = !bank_open[b] || (tras_cnt[b] == '0);
        CMD_REF, CMD_MRS, CMD_ZQCL: issue = all_closed && (glob_cnt == '0);
        default:  skip = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock_t) begin
    if (reset) begin
      out_cmd     <= CMD_DES;
      out_bg      <= '0;
      out_ba      <= '0;
      out_row     <= '0;
      out_col     <= '0;
      err_illegal <= 1'b0;
      bank_open   <= '0;
      tccd_cnt    <= '0;
      glob_cnt    <= '0;
      rd_pipe     <= '0;
      wr_pipe     <= '0;
      for (int i = 0; i < NBANK; i++) begin
        trcd_cnt[i] <= '0;
        tras_cnt[i] <= '0;
        trp_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NBANK; i++) begin
        if (trcd_cnt[i] != '0) trcd_cnt[i] <= trcd_cnt[i] - 1'b1;
        if (tras_cnt[i] != '0) tras_cnt[i] <= tras_cnt[i] - 1'b1;
        if (trp_cnt[i]  != '0) trp_cnt[i]  <= trp_cnt[i]  - 1'b1;
      end
      if (tccd_cnt != '0) tccd_cnt <= tccd_cnt - 1'b1;
      if (glob_cnt != '0) glob_cnt <= glob_cnt - 1'b1;

      out_cmd     <= issue ? head.cmd : CMD_DES;
      out_bg      <= issue ? head.bg  : '0;
      out_ba      <= issue ? head.ba  : '0;
      out_row     <= issue ? head.row : '0;
      out_col     <= issue ? head.col : '0;
      err_illegal <= illegal;

      // Strobe lines tap the registered command so the pulse lands CL/CWL after out_cmd.
      rd_pipe <= {rd_pipe[CL-2:0],  out_cmd == CMD_CAS_R};
      wr_pipe <= {wr_pipe[CWL-2:0], out_cmd == CMD_CAS_W};

      if (issue) begin
        case (head.cmd)
          CMD_ACT: begin
            trcd_cnt[b]  <= RCD_W'(T_RCD - 1);
            tras_cnt[b]  <= RAS_W'(T_RAS - 1);
            bank_open[b] <= 1'b1;
          end
          CMD_CAS_R, CMD_CAS_W: tccd_cnt <= CCD_W'(T_CCD - 1);
          CMD_PRE: begin
            if (bank_open[b]) begin
              trp_cnt[b]   <= RP_W'(T_RP - 1);
              bank_open[b] <= 1'b0;
            end
          end
          CMD_REF:           glob_cnt <= GLOB_W'(T_RFC - 1);
          CMD_MRS, CMD_ZQCL: glob_cnt <= GLOB_W'(T_MOD - 1);
          default: ;
        endcase
      end
    end
  end

  assign rd_start = rd_pipe[CL-1];
  assign wr_start = wr_pipe[CWL-1];

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb/tb_ddr_cmd_scheduler.sv - scoreboard bench for ddr_cmd_scheduler with directed scenarios
module tb_ddr_cmd_scheduler;
  import ddr_cmd_scheduler_pkg::*;

  localparam int K_CMD = 0;
  localparam int K_ERR = 1;
  localparam int K_RD  = 2;
  localparam int K_WR  = 3;

  logic        clock_t = 1'b0;
  logic        reset   = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  cmd_e        req_cmd = CMD_DES;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [14:0] req_row = '0;
  logic [9:0]  req_col = '0;
  cmd_e        out_cmd;
  logic [1:0]  out_bg;
  logic [1:0]  out_ba;
  logic [14:0] out_row;
  logic [9:0]  out_col;
  logic        rd_start;
  logic        wr_start;
  logic        err_illegal;
  logic [15:0] bank_open;

  ddr_cmd_scheduler dut (
    .clock_t     (clock_t),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_bg      (req_bg),
    .req_ba      (req_ba),
    .req_row     (req_row),
    .req_col     (req_col),
    .out_cmd     (out_cmd),
    .out_bg      (out_bg),
    .out_ba      (out_ba),
    .out_row     (out_row),
    .out_col     (out_col),
    .rd_start    (rd_start),
    .wr_start    (wr_start),
    .err_illegal (err_illegal),
    .bank_open   (bank_open)
  );

  always #5 clock_t = ~clock_t;

  int cyc = 0;
  always @(posedge clock_t) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    cmd_e        cmd;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [14:0] row;
    logic [9:0]  col;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input int k, input cmd_e cmd, input int bank,
                           input int row, input int col);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.cmd  = cmd;
    e.bg   = 2'(bank >> 2);
    e.ba   = 2'(bank);
    e.row  = 15'(row);
    e.col  = 10'(col);
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event at cycle %0d actual=present required=none", name, cyc);
    end else begin
      e = sb.pop_front();
      check({name, "_kind"},  kind, e.kind);
      check({name, "_cycle"}, cyc,  e.cyc);
      if (kind == K_CMD) begin
        check("cmd_code", int'(out_cmd), int'(e.cmd));
        check("cmd_bg",   int'(out_bg),  int'(e.bg));
        check("cmd_ba",   int'(out_ba),  int'(e.ba));
        check("cmd_row",  int'(out_row), int'(e.row));
        check("cmd_col",  int'(out_col), int'(e.col));
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clock_t);
      if (!reset) begin
        if (out_cmd != CMD_DES) observe(K_CMD, "cmd");
        if (err_illegal)        observe(K_ERR, "err_illegal");
        if (rd_start)           observe(K_RD,  "rd_start");
        if (wr_start)           observe(K_WR,  "wr_start");
      end
    end
  endtask

  task automatic drive(input cmd_e c, input int bank, input int row, input int col);
    req_valid = 1'b1;
    req_cmd   = c;
    req_bg    = 2'(bank >> 2);
    req_ba    = 2'(bank);
    req_row   = 15'(row);
    req_col   = 10'(col);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_cmd   = CMD_DES;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_t);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock_t);
  endtask

  task automatic do_reset();
    @(negedge clock_t);
    idle();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    check("rst_out_cmd",   int'(out_cmd), int'(CMD_DES));
    check("rst_out_row",   int'(out_row), 0);
    check("rst_bank_open", int'(bank_open), 0);
    check("rst_strobes",   int'({rd_start, wr_start, err_illegal}), 0);
    check("rst_req_ready", int'(req_ready), 1);
  endtask

  initial begin
    int c;
    int acc;
    fork
      monitor_loop();
    join_none

    // 1: ACT then CAS_R back to back
    do_reset();
    c = cyc;
    expect_ev(c + 2,  K_CMD, CMD_ACT,   0, 5, 0);
    expect_ev(c + 13, K_CMD, CMD_CAS_R, 0, 0, 8);
    expect_ev(c + 24, K_RD,  CMD_DES,   0, 0, 0);
    drive(CMD_ACT, 0, 5, 0);
    @(negedge clock_t) drive(CMD_CAS_R, 0, 0, 8);
    @(negedge clock_t) idle();
    wait_cycles(30);
    check("sb_drained_t1", sb.size(), 0);

    // 2: two CAS_W to bank 3 at tCCD spacing
    do_reset();
    c = cyc;
    expect_ev(c + 2,  K_CMD, CMD_ACT,   3, 2, 0);
    expect_ev(c + 13, K_CMD, CMD_CAS_W, 3, 0, 1);
    expect_ev(c + 17, K_CMD, CMD_CAS_W, 3, 0, 2);
    expect_ev(c + 22, K_WR,  CMD_DES,   0, 0, 0);
    expect_ev(c + 26, K_WR,  CMD_DES,   0, 0, 0);
    drive(CMD_ACT, 3, 2, 0);
    @(negedge clock_t) drive(CMD_CAS_W, 3, 0, 1);
    @(negedge clock_t) drive(CMD_CAS_W, 3, 0, 2);
    @(negedge clock_t) idle();
    wait_cycles(30);
    check("sb_drained_t2", sb.size(), 0);

    // 3: ACT/PRE/ACT on bank 1 under tRAS and tRP
    do_reset();
    c = cyc;
    expect_ev(c + 2,  K_CMD, CMD_ACT, 1, 7, 0);
    expect_ev(c + 30, K_CMD, CMD_PRE, 1, 0, 0);
    expect_ev(c + 41, K_CMD, CMD_ACT, 1, 9, 0);
    drive(CMD_ACT, 1, 7, 0);
    @(negedge clock_t) drive(CMD_PRE, 1, 0, 0);
    @(negedge clock_t) drive(CMD_ACT, 1, 9, 0);
    @(negedge clock_t) idle();
    wait_until(c + 10);
    check("bank1_open_after_act", int'(bank_open[1]), 1);
    wait_until(c + 35);
    check("bank1_closed_after_pre", int'(bank_open[1]), 0);
    wait_until(c + 45);
    check("bank1_reopened", int'(bank_open), 16'h0002);
    check("sb_drained_t3", sb.size(), 0);

    // 4: CAS_R to closed bank 2 is dropped, next head issues right after
    do_reset();
    c = cyc;
    expect_ev(c + 2, K_ERR, CMD_DES, 0, 0, 0);
    expect_ev(c + 3, K_CMD, CMD_PRE, 2, 0, 0);
    drive(CMD_CAS_R, 2, 0, 3);
    @(negedge clock_t) drive(CMD_PRE, 2, 0, 0);
    @(negedge clock_t) idle();
    wait_cycles(10);
    check("sb_drained_t4", sb.size(), 0);

    // 5: queue fills behind a tRFC stall
    do_reset();
    c = cyc;
    expect_ev(c + 2, K_CMD, CMD_REF, 0, 0, 0);
    for (int i = 0; i < 5; i++) expect_ev(c + 210 + i, K_CMD, CMD_ACT, i, i + 1, 0);
    drive(CMD_REF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_t);
      if (i == 3) check("ready_before_full", int'(req_ready), 1);
      drive(CMD_ACT, i, i + 1, 0);
    end
    @(negedge clock_t);
    check("ready_when_full", int'(req_ready), 0);
    drive(CMD_ACT, 4, 5, 0);
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock_t);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    check("fifth_accept_cycle", acc, c + 210);
    @(negedge clock_t) idle();
    wait_cycles(10);
    check("sb_drained_t5", sb.size(), 0);

    // 6: reset shortly after CAS_R kills the strobe and flushes the queue
    do_reset();
    c = cyc;
    expect_ev(c + 2,  K_CMD, CMD_ACT,   0, 1, 0);
    expect_ev(c + 13, K_CMD, CMD_CAS_R, 0, 0, 4);
    drive(CMD_ACT, 0, 1, 0);
    @(negedge clock_t) drive(CMD_CAS_R, 0, 0, 4);
    @(negedge clock_t) drive(CMD_REF, 0, 0, 0);
    @(negedge clock_t) idle();
    wait_until(c + 15);
    do_reset();
    wait_cycles(40);
    check("t6_bank_open", int'(bank_open), 0);
    check("t6_out_cmd", int'(out_cmd), int'(CMD_DES));
    check("sb_drained_t6", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
